// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the SD command engine
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_RECV,
        ST_GAP
    } state_t;

    localparam logic [2:0] ADDR_ARG      = 3'd0;
    localparam logic [2:0] ADDR_CMD      = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_RESP_ARG = 3'd3;
    localparam logic [2:0] ADDR_RESP_HDR = 3'd4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_CRC_ERR = 3;
    localparam int STAT_END_ERR = 4;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int FRAME_LEN = 48;
    localparam int CRC_SPAN  = 40;
    localparam int NCC_EDGES = 8;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial bit-in CRC7 (x^7+x^3+1), zero initial value
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;
    assign fb = din ^ crc[6];

    // Shift one message bit per enable; clear wins so a new frame starts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (enable)
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD CMD-line engine with register slave; optional SD_CMD_ENGINE_CRC_CHECK_EN
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    inout  wire         sd_cmd
);

    logic [7:0]  div_cnt;
    logic        div_wrap, tick_rise, tick_fall;
    state_t      state;
    logic [31:0] arg_reg, resp_arg;
    logic [5:0]  resp_index, bit_cnt, rx_cnt;
    logic [6:0]  resp_crc, tx_crc;
    logic        expect_resp, busy, done, timeout, crc_err, end_err;
    logic [15:0] wait_cnt;
    logic [2:0]  gap_cnt;
    logic [39:0] tx_shift;
    logic [44:0] rx_shift;
    logic        cmd_oe, cmd_out;
    logic        wr, cmd_start, tx_crc_en;
    logic [31:0] status;

    assign wr        = chipselect & ~write_n;
    assign cmd_start = wr && (address == ADDR_CMD) && (state == ST_IDLE);
    assign div_wrap  = (div_cnt == 8'(CLK_DIV - 1));
    assign tick_rise = div_wrap & ~sd_clk;
    assign tick_fall = div_wrap & sd_clk;
    assign tx_crc_en = (state == ST_SEND) && tick_fall && (bit_cnt < 6'(CRC_SPAN));

    // The line floats the moment reset rises, independent of the clock
    assign sd_cmd = (cmd_oe && !reset) ? cmd_out : 1'bz;

    // Free-running divider; the strobe direction follows the current sd_clk level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sd_clk  <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    sd_crc7 u_tx_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (cmd_start),
        .enable (tx_crc_en),
        .din    (tx_shift[39]),
        .crc    (tx_crc)
    );

`ifdef SD_CMD_ENGINE_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       rx_crc_en;
    assign rx_crc_en = tick_rise && (((state == ST_WAIT_RESP) && !sd_cmd) ||
                                     ((state == ST_RECV) && (rx_cnt < 6'(CRC_SPAN))));

    sd_crc7 u_rx_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (cmd_start),
        .enable (rx_crc_en),
        .din    (sd_cmd),
        .crc    (rx_crc)
    );
`endif

    // Command FSM plus register writes; FSM updates come last so they win over a status clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            arg_reg     <= '0;
            resp_arg    <= '0;
            resp_index  <= '0;
            resp_crc    <= '0;
            expect_resp <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            crc_err     <= 1'b0;
            end_err     <= 1'b0;
            bit_cnt     <= '0;
            rx_cnt      <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            cmd_oe      <= 1'b0;
            cmd_out     <= 1'b1;
        end else begin
            if (wr && address == ADDR_STATUS) begin
                done    <= 1'b0;
                timeout <= 1'b0;
                crc_err <= 1'b0;
                end_err <= 1'b0;
            end
            if (wr && address == ADDR_ARG && !busy)
                arg_reg <= writedata;

            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        expect_resp <= writedata[6];
                        tx_shift    <= {2'b01, writedata[5:0], arg_reg};
                        bit_cnt     <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tick_fall) begin
                        if (bit_cnt == 6'(FRAME_LEN)) begin
                            cmd_oe   <= 1'b0;
                            wait_cnt <= '0;
                            gap_cnt  <= '0;
                            state    <= expect_resp ? ST_WAIT_RESP : ST_GAP;
                        end else begin
                            cmd_oe  <= 1'b1;
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'(CRC_SPAN)) begin
                                // CRC is final now; queue its tail and the end bit behind it
                                cmd_out  <= tx_crc[6];
                                tx_shift <= {tx_crc[5:0], 1'b1, 33'd0};
                            end else begin
                                cmd_out  <= tx_shift[39];
                                tx_shift <= {tx_shift[38:0], 1'b0};
                            end
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (tick_rise) begin
                        if (!sd_cmd) begin
                            rx_cnt <= 6'd1;
                            state  <= ST_RECV;
                        end else if (wait_cnt == 16'(RESP_TIMEOUT - 1)) begin
                            timeout <= 1'b1;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                end
                ST_RECV: begin
                    if (tick_rise) begin
                        if (rx_cnt == 6'(FRAME_LEN - 1)) begin
                            end_err    <= ~sd_cmd;
`ifdef SD_CMD_ENGINE_CRC_CHECK_EN
                            crc_err    <= (rx_shift[6:0] != rx_crc);
`else
                            crc_err    <= 1'b0;
`endif
                            resp_index <= rx_shift[44:39];
                            resp_arg   <= rx_shift[38:7];
                            resp_crc   <= rx_shift[6:0];
                            gap_cnt    <= '0;
                            state      <= ST_GAP;
                        end else begin
                            rx_shift <= {rx_shift[43:0], sd_cmd};
                            rx_cnt   <= rx_cnt + 6'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick_rise) begin
                        if (gap_cnt == 3'(NCC_EDGES - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Assemble the STATUS word from the individual flags
    always_comb begin
        status               = '0;
        status[STAT_BUSY]    = busy;
        status[STAT_DONE]    = done;
        status[STAT_TIMEOUT] = timeout;
        status[STAT_CRC_ERR] = crc_err;
        status[STAT_END_ERR] = end_err;
    end

    // Read mux registered every clk regardless of chipselect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_ARG:      readdata <= arg_reg;
                ADDR_STATUS:   readdata <= status;
                ADDR_RESP_ARG: readdata <= resp_arg;
                ADDR_RESP_HDR: readdata <= {19'd0, resp_crc, resp_index};
                default:       readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - scoreboard bench for sd_cmd_engine with SD card line model
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        sd_clk;
    wire         sd_cmd;

    logic card_oe = 1'b0;
    logic card_bit = 1'b1;
    logic card_active = 1'b0;

    assign sd_cmd = card_oe ? card_bit : 1'bz;
    pullup (sd_cmd);

    always #5 clk = ~clk;

    sd_cmd_engine dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_clk     (sd_clk),
        .sd_cmd     (sd_cmd)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [47:0] exp_q[$];
    logic [47:0] resp_q[$];
    int rise_cnt = 0;
    int end_rise = 0;
    int frames_seen = 0;
    int mon_bits = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = m[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg, input logic tx);
        logic [39:0] m;
        m = {1'b0, tx, idx, arg};
        return {m, crc7(m), 1'b1};
    endfunction

    function automatic logic [31:0] resp_status(input logic [47:0] f);
        logic [31:0] st;
        st = 32'h02;
`ifdef SD_CMD_ENGINE_CRC_CHECK_EN
        if (f[7:1] != crc7(f[47:8])) st = st | 32'h08;
`endif
        if (!f[0]) st = st | 32'h10;
        return st;
    endfunction

    always @(posedge sd_clk) rise_cnt <= rise_cnt + 1;

    task automatic send_resp(input logic [47:0] f);
        card_active = 1'b1;
        repeat (2) @(negedge sd_clk);
        for (int i = 47; i >= 0; i--) begin
            card_oe  = 1'b1;
            card_bit = f[i];
            @(negedge sd_clk);
        end
        card_oe     = 1'b0;
        card_bit    = 1'b1;
        card_active = 1'b0;
    endtask

    initial begin : monitor
        logic [47:0] got;
        logic aborted;
        forever begin
            @(posedge sd_clk);
            if (!reset && !card_active && sd_cmd === 1'b0) begin
                got = '0;
                mon_bits = 1;
                aborted = 1'b0;
                while (mon_bits < 48 && !aborted) begin
                    @(posedge sd_clk or posedge reset);
                    if (reset) aborted = 1'b1;
                    else begin
                        got = {got[46:0], sd_cmd};
                        mon_bits++;
                    end
                end
                if (!aborted) begin
                    #1 end_rise = rise_cnt;
                    frames_seen++;
                    if (exp_q.size() > 0) chk("frame", got, exp_q.pop_front());
                    else chk("frame_extra", exp_q.size(), 1);
                    if (resp_q.size() > 0) send_resp(resp_q.pop_front());
                end
                mon_bits = 0;
            end
        end
    end

    task automatic avl_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic avl_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_done(output int rises);
        int n;
        address = 3'd2;
        repeat (3) @(negedge clk);
        n = 0;
        while (readdata[0] !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("busy_wait_expired", readdata[0], 0);
        rises = rise_cnt - end_rise;
    endtask

    task automatic run_cmd(input logic [31:0] arg, input logic [6:0] cmd, input logic [47:0] exp_frame,
                           input logic do_reply, input logic [47:0] reply, output int rises);
        avl_write(3'd2, 32'd0);
        avl_write(3'd0, arg);
        exp_q.push_back(exp_frame);
        if (do_reply) resp_q.push_back(reply);
        avl_write(3'd1, {25'd0, cmd});
        wait_done(rises);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] d;
        logic [47:0] rf;
        logic [5:0]  idx;
        logic [31:0] arg;
        int rises, r0, fs0, n;

        repeat (5) @(negedge clk);
        chk("reset_sd_clk", sd_clk, 0);
        chk("reset_cmd_oe", dut.cmd_oe, 0);
        reset = 1'b0;
        for (int a = 0; a < 5; a++) begin
            avl_read(3'(a), d);
            chk($sformatf("reset_reg%0d", a), d, 0);
        end

        r0 = rise_cnt;
        repeat (40) @(negedge clk);
        chk("sd_clk_rate", rise_cnt - r0, 10);

        run_cmd(32'd0, 7'h00, 48'h40_00000000_95, 1'b0, 48'd0, rises);
        chk("cmd0_gap_rises", rises, 8);
        avl_read(3'd2, d);
        chk("cmd0_status", d, 32'h02);
        avl_write(3'd2, 32'd0);
        avl_read(3'd2, d);
        chk("status_clear", d, 32'h00);

        rf = 48'h08_000001AA_87;
        run_cmd(32'h1AA, 7'h48, 48'h48_000001AA_87, 1'b1, rf, rises);
        avl_read(3'd3, d);
        chk("cmd8_resp_arg", d, 32'h1AA);
        avl_read(3'd4, d);
        chk("cmd8_resp_hdr", d, {19'd0, rf[7:1], rf[45:40]});
        avl_read(3'd2, d);
        chk("cmd8_status", d, resp_status(rf));
        avl_read(3'd0, d);
        chk("arg_readback", d, 32'h1AA);

        for (int k = 0; k < 3; k++) begin
            idx = 6'($urandom_range(0, 63));
            arg = $urandom;
            rf  = make_frame(6'($urandom_range(0, 63)), $urandom, 1'b0);
            run_cmd(arg, {1'b1, idx}, make_frame(idx, arg, 1'b1), 1'b1, rf, rises);
            avl_read(3'd3, d);
            chk("rand_resp_arg", d, rf[39:8]);
            avl_read(3'd4, d);
            chk("rand_resp_hdr", d, {19'd0, rf[7:1], rf[45:40]});
            avl_read(3'd2, d);
            chk("rand_status", d, 32'h02);
        end

        rf = 48'h08_000001AA_86;
        run_cmd(32'h1AA, 7'h48, 48'h48_000001AA_87, 1'b1, rf, rises);
        avl_read(3'd2, d);
        chk("badcrc_status", d, resp_status(rf));
        avl_read(3'd4, d);
        chk("badcrc_raw_hdr", d, {19'd0, rf[7:1], rf[45:40]});

        rf = make_frame(6'd3, 32'hCAFE0001, 1'b0);
        rf[0] = 1'b0;
        run_cmd(32'h55, 7'h43, make_frame(6'd3, 32'h55, 1'b1), 1'b1, rf, rises);
        avl_read(3'd2, d);
        chk("enderr_status", d, 32'h12);

        run_cmd(32'h1AA, 7'h48, 48'h48_000001AA_87, 1'b0, 48'd0, rises);
        chk("timeout_rises", rises, 64 + 8);
        avl_read(3'd2, d);
        chk("timeout_status", d, 32'h06);

        avl_write(3'd2, 32'd0);
        avl_write(3'd0, 32'h12345678);
        exp_q.push_back(make_frame(6'd5, 32'h12345678, 1'b1));
        fs0 = frames_seen;
        avl_write(3'd1, 32'h05);
        repeat (30) @(negedge clk);
        avl_write(3'd1, 32'h7F);
        avl_write(3'd0, 32'hFFFFFFFF);
        wait_done(rises);
        chk("busy_one_frame", frames_seen - fs0, 1);
        avl_read(3'd0, d);
        chk("busy_arg_kept", d, 32'h12345678);
        avl_read(3'd2, d);
        chk("busy_status", d, 32'h02);

        avl_write(3'd2, 32'd0);
        fs0 = frames_seen;
        avl_write(3'd1, 32'h11);
        n = 0;
        while (mon_bits != 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("bit20_wait_expired", mon_bits, 20);
        @(negedge sd_clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_cmd_oe", dut.cmd_oe, 0);
        chk("abort_line_released", sd_cmd, 1);
        chk("abort_sd_clk", sd_clk, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        avl_read(3'd2, d);
        chk("abort_status", d, 32'h00);
        repeat (200) @(negedge clk);
        chk("abort_no_frame", frames_seen - fs0, 0);

        arg = $urandom;
        run_cmd(arg, 7'h02, make_frame(6'd2, arg, 1'b1), 1'b0, 48'd0, rises);
        avl_read(3'd2, d);
        chk("recover_status", d, 32'h02);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
